// File: rtl/vec_mac_pkg.sv
// Shared encodings and decode helpers for the vector multiply-accumulate pipeline.
package vec_mac_pkg;

  typedef enum logic [2:0] {
    VMACC_VV  = 3'b000,
    VMACC_VX  = 3'b001,
    VNMSAC_VV = 3'b010,
    VNMSAC_VX = 3'b011,
    VMADD_VV  = 3'b100,
    VMADD_VX  = 3'b101,
    VNMSUB_VV = 3'b110,
    VNMSUB_VX = 3'b111
  } accum_op_e;

  localparam logic [1:0] SEW8     = 2'b00;
  localparam logic [1:0] SEW16    = 2'b01;
  localparam logic [1:0] SEW32    = 2'b10;
  localparam logic [1:0] SEW_RSVD = 2'b11;

  function automatic logic is_illegal(input logic [1:0] sew, input logic widen,
                                      input logic widen_en);
    return (sew == SEW_RSVD) || (widen && (sew == SEW32)) || (widen && !widen_en);
  endfunction

  function automatic logic op_is_vx(input accum_op_e op);
    return op inside {VMACC_VX, VNMSAC_VX, VMADD_VX, VNMSUB_VX};
  endfunction

  function automatic logic op_is_sub(input accum_op_e op);
    return op inside {VNMSAC_VV, VNMSAC_VX, VNMSUB_VV, VNMSUB_VX};
  endfunction

  // VMADD/VNMSUB multiply by vd and accumulate onto vs2.
  function automatic logic op_mul_vd(input accum_op_e op);
    return op inside {VMADD_VV, VMADD_VX, VNMSUB_VV, VNMSUB_VX};
  endfunction

  function automatic logic [15:0] ext8(input logic [7:0] v, input logic sgn);
    return sgn ? {{8{v[7]}}, v} : {8'h00, v};
  endfunction

  function automatic logic [31:0] ext16(input logic [15:0] v, input logic sgn);
    return sgn ? {{16{v[15]}}, v} : {16'h0000, v};
  endfunction

endpackage

// File: rtl/vec_lane_mult.sv
// One 32-bit slice of the vector multiplier. Non-widening products occupy the low
// 32 bits; widening packs 2*SEW products across the full 64-bit output.
module vec_lane_mult
  import vec_mac_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [1:0]  sew_i,
  input  logic        widen_i,
  input  logic        signed_i,
  output logic [63:0] prod_o
);

  always_comb begin
    prod_o = '0;
    case (sew_i)
      SEW8: begin
        for (int e = 0; e < 4; e++) begin
          if (widen_i)
            prod_o[16*e +: 16] = ext8(a_i[8*e +: 8], signed_i) * ext8(b_i[8*e +: 8], signed_i);
          else
            prod_o[8*e +: 8] = a_i[8*e +: 8] * b_i[8*e +: 8];
        end
      end
      SEW16: begin
        for (int e = 0; e < 2; e++) begin
          if (widen_i)
            prod_o[32*e +: 32] = ext16(a_i[16*e +: 16], signed_i) * ext16(b_i[16*e +: 16], signed_i);
          else
            prod_o[16*e +: 16] = a_i[16*e +: 16] * b_i[16*e +: 16];
        end
      end
      default: prod_o[31:0] = a_i * b_i;
    endcase
  end

endmodule

// File: rtl/vector_mac_pipe.sv
// Two-stage vector multiply-accumulate: stage M holds products and addend,
// stage A holds the element-wise sum presented on the result port.
module vector_mac_pipe
  import vec_mac_pkg::*;
#(
  parameter int VLEN     = 512,
  parameter bit WIDEN_EN = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [VLEN-1:0] data_A,
  input  logic [VLEN-1:0] data_B,
  input  logic [VLEN-1:0] data_C,
  input  logic [31:0]     scalar_rs1,
  input  logic [2:0]      accum_op,
  input  logic [1:0]      sew,
  input  logic            signed_mode,
  input  logic            widen,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [VLEN-1:0] result,
  output logic            illegal
);

  localparam int NLANE = VLEN / 32;
  localparam int NWIDE = VLEN / 64;

  accum_op_e       op;
  logic            req_illegal;
  logic            accept;
  logic            a_adv;
  logic [1:0]      ew_d;
  logic [VLEN-1:0] splat, src1, mul_b, addend, prod_d, sum_d;
  logic [63:0]     lane_prod [NLANE];

  logic            m_valid_q, m_valid_d, m_sub_q, m_ill_q;
  logic [1:0]      m_ew_q;
  logic [VLEN-1:0] m_prod_q, m_add_q;
  logic            a_valid_q, a_valid_d, a_ill_q;
  logic [VLEN-1:0] a_res_q;

  assign op          = accum_op_e'(accum_op);
  assign req_illegal = is_illegal(sew, widen, WIDEN_EN);
  assign ew_d        = widen ? sew + 2'd1 : sew;
  assign src1        = op_is_vx(op) ? splat : data_A;
  assign mul_b       = op_mul_vd(op) ? data_C : data_B;
  assign addend      = op_mul_vd(op) ? data_B : data_C;

  assign a_adv    = !a_valid_q || out_ready;
  assign in_ready = !m_valid_q || a_adv;
  assign accept   = in_valid && in_ready && !flush;

  always_comb begin
    case (sew)
      SEW8:    splat = {(VLEN/8){scalar_rs1[7:0]}};
      SEW16:   splat = {(VLEN/16){scalar_rs1[15:0]}};
      default: splat = {(VLEN/32){scalar_rs1}};
    endcase
  end

  for (genvar gi = 0; gi < NLANE; gi++) begin : g_lane
    vec_lane_mult u_lane (
      .a_i     (src1[32*gi +: 32]),
      .b_i     (mul_b[32*gi +: 32]),
      .sew_i   (sew),
      .widen_i (widen),
      .signed_i(signed_mode),
      .prod_o  (lane_prod[gi])
    );
  end

  // Widening sources come from the low half, so only the first NWIDE lanes carry data.
  always_comb begin
    prod_d = '0;
    if (widen) begin
      for (int i = 0; i < NWIDE; i++) prod_d[64*i +: 64] = lane_prod[i];
    end else begin
      for (int i = 0; i < NLANE; i++) prod_d[32*i +: 32] = lane_prod[i][31:0];
    end
  end

  always_comb begin
    sum_d = '0;
    for (int c = 0; c < NLANE; c++) begin
      case (m_ew_q)
        2'd0: for (int e = 0; e < 4; e++)
          sum_d[32*c+8*e +: 8] = m_sub_q ? m_add_q[32*c+8*e +: 8] - m_prod_q[32*c+8*e +: 8]
                                         : m_add_q[32*c+8*e +: 8] + m_prod_q[32*c+8*e +: 8];
        2'd1: for (int e = 0; e < 2; e++)
          sum_d[32*c+16*e +: 16] = m_sub_q ? m_add_q[32*c+16*e +: 16] - m_prod_q[32*c+16*e +: 16]
                                           : m_add_q[32*c+16*e +: 16] + m_prod_q[32*c+16*e +: 16];
        default:
          sum_d[32*c +: 32] = m_sub_q ? m_add_q[32*c +: 32] - m_prod_q[32*c +: 32]
                                      : m_add_q[32*c +: 32] + m_prod_q[32*c +: 32];
      endcase
    end
  end

  always_comb begin
    m_valid_d = m_valid_q;
    a_valid_d = a_valid_q;
    if (flush) begin
      m_valid_d = 1'b0;
      a_valid_d = 1'b0;
    end else begin
      if (in_ready) m_valid_d = in_valid;
      if (a_adv)    a_valid_d = m_valid_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_valid_q <= 1'b0;
      m_sub_q   <= 1'b0;
      m_ill_q   <= 1'b0;
      m_ew_q    <= 2'd0;
      m_prod_q  <= '0;
      m_add_q   <= '0;
      a_valid_q <= 1'b0;
      a_ill_q   <= 1'b0;
      a_res_q   <= '0;
    end else begin
      m_valid_q <= m_valid_d;
      a_valid_q <= a_valid_d;
      if (accept) begin
        m_prod_q <= prod_d;
        m_add_q  <= addend;
        m_sub_q  <= op_is_sub(op);
        m_ew_q   <= ew_d;
        m_ill_q  <= req_illegal;
      end
      if (a_adv && m_valid_q && !flush) begin
        a_res_q <= m_ill_q ? '0 : sum_d;
        a_ill_q <= m_ill_q;
      end
    end
  end

  assign out_valid = a_valid_q;
  assign result    = a_res_q;
  assign illegal   = a_valid_q && a_ill_q;

endmodule

// File: doc/vector_mac_pipe.md
VECTOR_MAC_PIPE -- requirements
Module: vector_mac_pipe

Interface
REQ-001 Parameter VLEN, default 512: vector register width in bits; SHALL be a multiple of 64.
REQ-002 Parameter WIDEN_EN, default 1: when 0, widening requests SHALL be treated as illegal.
REQ-003 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 in_valid / in_ready  in / out  1 / 1  request handshake; a transfer occurs when both are high on a rising edge.
REQ-006 data_A, data_B, data_C  in  VLEN each  vs1, vs2 and vd operands.
REQ-007 scalar_rs1  in  32  scalar operand for *_VX ops; the low SEW bits are splatted to every element.
REQ-008 accum_op  in  3  000 VMACC_VV, 001 VMACC_VX, 010 VNMSAC_VV, 011 VNMSAC_VX, 100 VMADD_VV, 101 VMADD_VX, 110 VNMSUB_VV, 111 VNMSUB_VX.
REQ-009 sew  in  2  00 = 8-bit, 01 = 16-bit, 10 = 32-bit, 11 = illegal.
REQ-010 signed_mode / widen  in  1 / 1  signed multiply; widening (2*SEW result) mode.
REQ-011 flush  in  1  synchronous pipeline kill.
REQ-012 out_valid / out_ready  out / in  1 / 1  result handshake.
REQ-013 result  out  VLEN  vd write data.
REQ-014 illegal  out  1  set with a result whose request was illegal.

Function
REQ-015 Operand roles: VMACC/VNMSAC SHALL compute mul(src1, data_B) and add data_C; VMADD/VNMSUB SHALL compute mul(src1, data_C) and add data_B. src1 is data_A for _VV ops and the scalar splat for _VX ops.
REQ-016 VNMSAC and VNMSUB SHALL subtract the product from the addend; VMACC and VMADD SHALL add it.
REQ-017 Non-widening ops SHALL keep the low SEW bits of each product, with modulo-2^SEW wraparound on add and subtract. signed_mode SHALL not affect the result.
REQ-018 Widening ops SHALL take multiplier operands from the low VLEN/2 bits of each source. Each operand SHALL be sign-extended when signed_mode=1 and zero-extended otherwise. The product and addend SHALL be 2*SEW wide; the addend is full-width data_C or data_B.
REQ-019 Pipeline: stage M registers the per-lane products and the addend; stage A registers the sum. result SHALL appear exactly 2 cycles after acceptance when out_ready stays high.
REQ-020 Accepted requests SHALL complete in order; there SHALL be no loss and no duplication.
REQ-021 in_ready SHALL equal !(M valid && A valid && !out_ready). Full throughput is one op per cycle.
REQ-022 While out_valid=1 and out_ready=0, result and illegal SHALL hold stable.
REQ-023 A request is illegal when sew=11, or when widen=1 and sew=10, or when widen=1 and WIDEN_EN=0. An illegal request SHALL still be accepted and SHALL produce result=0 with illegal=1 at normal latency.
REQ-024 flush SHALL invalidate both stages on the next edge and SHALL override same-cycle acceptance. in_ready SHALL be 1 in the following cycle.
REQ-025 Simultaneous output drain and input accept SHALL advance the pipeline with no bubble.

Reset
REQ-026 While reset=0: stage valid bits, out_valid, illegal and result SHALL be 0; in_ready SHALL be 1.
REQ-027 An asserted reset SHALL discard in-flight operations; no result from them SHALL ever be emitted.

Structure
REQ-028 The accum_op encoding enum, the SEW encodings and the illegal-decode function SHALL live in a shared package, vec_mac_pkg.
REQ-029 The per-element SEW-configurable multiply SHALL be one sub-module, vec_lane_mult, instantiated VLEN/32 times.

Verification
REQ-030 VLEN=64, sew=00, VMACC_VV, all bytes A=0x03, B=0x04, C=0x05 -> every byte 0x11, out_valid exactly 2 cycles after acceptance.
REQ-031 sew=10, VNMSAC_VV, A=2, B=3, C=10 -> 0x00000004; A=2, B=3, C=5 -> 0xFFFFFFFF.
REQ-032 sew=01, VMADD_VX, scalar_rs1=0x00010002, C=0x0010, B=0x0001 -> every halfword 0x0021.
REQ-033 widen=1, sew=00, A=0xFF, B=0x02, C=0x0005, VMACC_VV -> signed_mode=1 gives 0x0003; signed_mode=0 gives 0x0203.
REQ-034 Back-to-back ops X and Y, then out_ready=0 for 3 cycles -> in_ready=0, result holds X, then X and Y are delivered in order.
REQ-035 sew=11 -> result=0 and illegal=1. flush or reset mid-flight -> no out_valid pulse for killed ops.
